// File: rtl/fetch_stage.sv
// fetch_stage: PC owner issuing one-outstanding imem fetches into the IF/ID register, with stall skid and branch redirect/flush
module fetch_stage #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              StallF,
  input  logic              StallD,
  input  logic              pc_src,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] id_instr,
  output logic [ADDR_W-1:0] id_pc_plus4,
  output logic              id_valid,
  output logic              fetch_busy
);
  typedef enum logic [1:0] {REQ, WAIT, HOLD} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] pc, pc_nx, tgt, tgt_nx, pc_plus4;
  logic [DATA_W-1:0] skid;
  logic kill, kill_nx, req_q, redir, accept, deliver;
  assign pc_plus4 = pc + ADDR_W'(4);
  assign redir = pc_src && !StallD;
  assign imem_req = rst_n && state == REQ && (!StallF || req_q);
  assign imem_addr = pc;
  assign accept = imem_req && imem_ready;
  assign fetch_busy = state != REQ;
  always_comb begin
    state_nx = state;
    pc_nx = pc;
    kill_nx = kill;
    tgt_nx = tgt;
    deliver = 1'b0;
    case (state)
      REQ: begin
        if (redir && imem_req) begin
          kill_nx = 1'b1;
          tgt_nx = branch_target;
        end else if (redir) pc_nx = branch_target;
        if (accept) state_nx = WAIT;
      end
      WAIT: begin
        if (imem_rvalid && (kill || redir)) begin
          pc_nx = redir ? branch_target : tgt;
          kill_nx = 1'b0;
          state_nx = REQ;
        end else if (imem_rvalid && !StallD) begin
          deliver = 1'b1;
          pc_nx = pc_plus4;
          state_nx = REQ;
        end else if (imem_rvalid) state_nx = HOLD;
        else if (redir) begin
          kill_nx = 1'b1;
          tgt_nx = branch_target;
        end
      end
      HOLD: begin
        if (!StallD) begin
          state_nx = REQ;
          deliver = !pc_src;
          pc_nx = pc_src ? branch_target : pc_plus4;
        end
      end
      default: state_nx = REQ;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= REQ;
      pc <= RESET_PC;
      tgt <= RESET_PC;
      kill <= 1'b0;
      req_q <= 1'b0;
      skid <= '0;
      id_instr <= '0;
      id_pc_plus4 <= '0;
      id_valid <= 1'b0;
    end else begin
      state <= state_nx;
      pc <= pc_nx;
      tgt <= tgt_nx;
      kill <= kill_nx;
      req_q <= imem_req && !imem_ready;
      if (state == WAIT && imem_rvalid) skid <= imem_rdata;
      if (!StallD) begin
        id_valid <= deliver;
        id_instr <= deliver ? (state == HOLD ? skid : imem_rdata) : '0;
        if (deliver) id_pc_plus4 <= pc_plus4;
      end
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed self-checking bench for fetch_stage
module tb_fetch_stage;
  logic clk = 0, rst_n = 1, StallF = 0, StallD = 0, pc_src = 0, imem_ready = 0, imem_rvalid = 0;
  logic [31:0] branch_target = 0, imem_rdata = 0;
  logic imem_req, id_valid, fetch_busy, w_req, w_valid, w_busy;
  logic [31:0] imem_addr, id_instr, id_pc_plus4, w_addr, w_instr, w_plus4;
  int pass_cnt = 0, total_cnt = 0;
  fetch_stage u_dut (
    .clk(clk), .rst_n(rst_n), .StallF(StallF), .StallD(StallD), .pc_src(pc_src),
    .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .id_instr(id_instr), .id_pc_plus4(id_pc_plus4), .id_valid(id_valid), .fetch_busy(fetch_busy)
  );
  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst_n(rst_n), .StallF(StallF), .StallD(StallD), .pc_src(pc_src),
    .branch_target(branch_target), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .id_instr(w_instr), .id_pc_plus4(w_plus4), .id_valid(w_valid), .fetch_busy(w_busy)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    StallF = 0; StallD = 0; pc_src = 0; imem_ready = 0; imem_rvalid = 0;
    @(negedge clk) rst_n = 0;
    tick;
    @(negedge clk) rst_n = 1;
    #1;
  endtask
  task automatic test_reset;
    #3 rst_n = 0;
    #2;
    total_cnt++; if (imem_req !== 1'b0) $display("FAIL reset_req got %b want 0", imem_req); else pass_cnt++;
    total_cnt++; if (id_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", id_valid); else pass_cnt++;
    total_cnt++; if (id_instr !== 32'h0) $display("FAIL reset_instr got %h want 0", id_instr); else pass_cnt++;
    total_cnt++; if (id_pc_plus4 !== 32'h0) $display("FAIL reset_plus4 got %h want 0", id_pc_plus4); else pass_cnt++;
    total_cnt++; if (fetch_busy !== 1'b0) $display("FAIL reset_busy got %b want 0", fetch_busy); else pass_cnt++;
    @(negedge clk) rst_n = 1;
    #1;
    total_cnt++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) $display("FAIL first_req got %b/%h want 1/0", imem_req, imem_addr); else pass_cnt++;
  endtask
  task automatic test_zero_wait;
    imem_ready = 1;
    for (int k = 0; k < 3; k++) begin
      total_cnt++; if (imem_req !== 1'b1 || imem_addr !== 32'(4 * k)) $display("FAIL zw_addr%0d got %b/%h want 1/%h", k, imem_req, imem_addr, 4 * k); else pass_cnt++;
      tick;
      imem_rvalid = 1; imem_rdata = 32'hA000_0000 + 32'(k);
      #1;
      total_cnt++; if (fetch_busy !== 1'b1 || id_valid !== 1'b0) $display("FAIL zw_wait%0d got busy %b valid %b want 1/0", k, fetch_busy, id_valid); else pass_cnt++;
      tick;
      imem_rvalid = 0;
      total_cnt++; if (id_valid !== 1'b1 || id_instr !== 32'hA000_0000 + 32'(k) || id_pc_plus4 !== 32'(4 * k + 4))
        $display("FAIL zw_id%0d got %b/%h/%h want 1/%h/%h", k, id_valid, id_instr, id_pc_plus4, 32'hA000_0000 + 32'(k), 4 * k + 4); else pass_cnt++;
    end
  endtask
  task automatic test_wait_states;
    imem_ready = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) imem_ready = 1;
      if (i > 0) StallF = 1;
      #1;
      total_cnt++; if (imem_req !== 1'b1 || imem_addr !== 32'd12) $display("FAIL ws_stable%0d got %b/%h want 1/c", i, imem_req, imem_addr); else pass_cnt++;
      if (i > 0) begin
        total_cnt++; if (id_valid !== 1'b0) $display("FAIL ws_bubble%0d got %b want 0", i, id_valid); else pass_cnt++;
      end
      tick;
    end
    StallF = 0; imem_rvalid = 1; imem_rdata = 32'hB000_0000;
    tick;
    imem_rvalid = 0;
    total_cnt++; if (id_valid !== 1'b1 || id_instr !== 32'hB000_0000 || id_pc_plus4 !== 32'd16 || imem_addr !== 32'd16)
      $display("FAIL ws_deliver got %b/%h/%h/%h want 1/b0000000/10/10", id_valid, id_instr, id_pc_plus4, imem_addr); else pass_cnt++;
  endtask
  task automatic test_stall_skid;
    tick;
    StallD = 1; imem_rvalid = 1; imem_rdata = 32'hC000_0000;
    tick;
    imem_rvalid = 0;
    for (int j = 0; j < 2; j++) begin
      total_cnt++; if (fetch_busy !== 1'b1 || id_valid !== 1'b0 || id_instr !== 32'h0 || imem_req !== 1'b0)
        $display("FAIL skid_hold%0d got busy %b valid %b instr %h req %b want 1/0/0/0", j, fetch_busy, id_valid, id_instr, imem_req); else pass_cnt++;
      if (j == 0) tick;
    end
    StallD = 0;
    tick;
    total_cnt++; if (id_valid !== 1'b1 || id_instr !== 32'hC000_0000 || id_pc_plus4 !== 32'd20 || fetch_busy !== 1'b0 || imem_addr !== 32'd20)
      $display("FAIL skid_release got %b/%h/%h/%b/%h want 1/c0000000/14/0/14", id_valid, id_instr, id_pc_plus4, fetch_busy, imem_addr); else pass_cnt++;
  endtask
  task automatic test_redirect;
    tick;
    pc_src = 1; branch_target = 32'h100;
    tick;
    pc_src = 0;
    total_cnt++; if (id_valid !== 1'b0 || fetch_busy !== 1'b1) $display("FAIL rd_flush got valid %b busy %b want 0/1", id_valid, fetch_busy); else pass_cnt++;
    imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF;
    tick;
    imem_rvalid = 0;
    total_cnt++; if (id_valid !== 1'b0 || id_instr !== 32'h0 || imem_req !== 1'b1 || imem_addr !== 32'h100)
      $display("FAIL rd_drop got %b/%h/%b/%h want 0/0/1/100", id_valid, id_instr, imem_req, imem_addr); else pass_cnt++;
    tick;
    imem_rvalid = 1; imem_rdata = 32'hE000_0000;
    tick;
    imem_rvalid = 0;
    total_cnt++; if (id_instr !== 32'hE000_0000 || id_pc_plus4 !== 32'h104) $display("FAIL rd_target got %h/%h want e0000000/104", id_instr, id_pc_plus4); else pass_cnt++;
    tick;
    imem_rvalid = 1; imem_rdata = 32'hDEAD_0001; pc_src = 1; branch_target = 32'h200;
    tick;
    imem_rvalid = 0; pc_src = 0;
    total_cnt++; if (id_valid !== 1'b0 || imem_addr !== 32'h200 || fetch_busy !== 1'b0)
      $display("FAIL rd_simul got %b/%h/%b want 0/200/0", id_valid, imem_addr, fetch_busy); else pass_cnt++;
    imem_ready = 0; pc_src = 1; branch_target = 32'h300;
    tick;
    pc_src = 0;
    total_cnt++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) $display("FAIL rd_unacc_stable got %b/%h want 1/200", imem_req, imem_addr); else pass_cnt++;
    imem_ready = 1;
    tick;
    imem_rvalid = 1; imem_rdata = 32'hDEAD_0002;
    tick;
    imem_rvalid = 0;
    total_cnt++; if (id_valid !== 1'b0 || imem_addr !== 32'h300) $display("FAIL rd_unacc_restart got %b/%h want 0/300", id_valid, imem_addr); else pass_cnt++;
  endtask
  task automatic test_wrap;
    do_reset;
    imem_ready = 1;
    total_cnt++; if (w_req !== 1'b1 || w_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_first got %b/%h want 1/fffffffc", w_req, w_addr); else pass_cnt++;
    tick;
    imem_rvalid = 1; imem_rdata = 32'hF000_0000;
    tick;
    imem_rvalid = 0;
    total_cnt++; if (w_valid !== 1'b1 || w_plus4 !== 32'h0 || w_addr !== 32'h0 || w_instr !== 32'hF000_0000)
      $display("FAIL wrap_plus4 got %b/%h/%h/%h want 1/0/0/f0000000", w_valid, w_plus4, w_addr, w_instr); else pass_cnt++;
  endtask
  task automatic test_async_reset;
    do_reset;
    imem_ready = 1;
    tick;
    imem_rvalid = 1; imem_rdata = 32'h0000_0011;
    tick;
    imem_rvalid = 0; StallD = 1;
    tick;
    total_cnt++; if (id_valid !== 1'b1 || fetch_busy !== 1'b1 || id_pc_plus4 !== 32'd4) $display("FAIL ar_pre got %b/%b/%h want 1/1/4", id_valid, fetch_busy, id_pc_plus4); else pass_cnt++;
    #2 rst_n = 0;
    #1;
    total_cnt++; if (imem_req !== 1'b0 || fetch_busy !== 1'b0 || id_valid !== 1'b0 || id_instr !== 32'h0 || id_pc_plus4 !== 32'h0)
      $display("FAIL ar_async got %b/%b/%b/%h/%h want 0/0/0/0/0", imem_req, fetch_busy, id_valid, id_instr, id_pc_plus4); else pass_cnt++;
    StallD = 0;
    @(negedge clk) rst_n = 1;
    imem_rvalid = 1; imem_rdata = 32'h0BAD_0BAD;
    #1;
    total_cnt++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) $display("FAIL ar_restart got %b/%h want 1/0", imem_req, imem_addr); else pass_cnt++;
    tick;
    imem_rvalid = 0;
    total_cnt++; if (id_valid !== 1'b0 || fetch_busy !== 1'b1) $display("FAIL ar_late_ignored got %b/%b want 0/1", id_valid, fetch_busy); else pass_cnt++;
    imem_rvalid = 1; imem_rdata = 32'h0000_0022;
    tick;
    imem_rvalid = 0;
    total_cnt++; if (id_valid !== 1'b1 || id_instr !== 32'h0000_0022 || id_pc_plus4 !== 32'd4)
      $display("FAIL ar_fetch got %b/%h/%h want 1/22/4", id_valid, id_instr, id_pc_plus4); else pass_cnt++;
  endtask
  initial begin
    test_reset;
    test_zero_wait;
    test_wait_states;
    test_stall_skid;
    test_redirect;
    test_wrap;
    test_async_reset;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
